vcve2_vlsu_seq: RTL and testbench

Vector load/store sequencer that sits directly upstream of the data-memory arbiter's VRF port.
Accepts one vector memory operation at a time and splits it into word (32-bit) memory transactions using the OBI-style req/gnt/rvalid protocol.
Loads write returned words into the VRF; stores read VRF words and send them to memory.
Signals completion, with an error flag, back to the vector control logic.

---
 rtl/vcve2_vlsu_pkg.sv | 15 +
 rtl/vcve2_vlsu_addr_gen.sv | 30 +++
 rtl/vcve2_vlsu_seq.sv | 103 ++++++++++
 tb/tb_vcve2_vlsu_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/vcve2_vlsu_pkg.sv
// vcve2_vlsu_pkg: shared types and constants for the vector load/store sequencer
package vcve2_vlsu_pkg;
  localparam int WORD_BYTES = 4;
  localparam int DEF_VLEN = 128;
  localparam int DEF_VRF_AW = 5;
  localparam int NWORDS_W = $clog2(DEF_VLEN / 32 * 8) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} vlsu_state_e;
  typedef struct packed {
    logic                  we;
    logic [31:0]           base;
    logic [31:0]           stride;
    logic [NWORDS_W-1:0]   nwords;
    logic [DEF_VRF_AW-1:0] vrf_base;
  } vlsu_op_t;
endpackage

// File: rtl/vcve2_vlsu_addr_gen.sv
// vcve2_vlsu_addr_gen: holds the accepted op, the address accumulator, issue count and VRF read index
module vcve2_vlsu_addr_gen
  import vcve2_vlsu_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  step_i,
  input  vlsu_op_t              op_i,
  output vlsu_op_t              op_o,
  output logic [NWORDS_W-1:0]   cnt_o,
  output logic [DEF_VRF_AW-1:0] vrf_raddr_o
);
  // The base field doubles as the running address: it advances by stride on each grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_o        <= '0;
      cnt_o       <= '0;
      vrf_raddr_o <= '0;
    end else if (load_i) begin
      op_o        <= op_i;
      cnt_o       <= '0;
      vrf_raddr_o <= op_i.vrf_base;
    end else if (step_i) begin
      op_o.base   <= op_o.base + op_o.stride;
      cnt_o       <= cnt_o + 1'b1;
      vrf_raddr_o <= vrf_raddr_o + 1'b1;
    end
  end
endmodule

// File: rtl/vcve2_vlsu_seq.sv
// vcve2_vlsu_seq: splits one vector load/store into OBI word transactions against the VRF.
// VCVE2_VLSU_STRIDE_EN enables arbitrary strides; otherwise the stride is fixed to one word.
module vcve2_vlsu_seq
  import vcve2_vlsu_pkg::*;
#(
  parameter int VLEN            = DEF_VLEN,
  parameter int MAX_OUTSTANDING = 2,
  parameter int VRF_AW          = DEF_VRF_AW,
  localparam int NWW            = $clog2(VLEN / 32 * 8) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic              op_we_i,
  input  logic [31:0]       op_base_i,
  input  logic [31:0]       op_stride_i,
  input  logic [NWW-1:0]    op_nwords_i,
  input  logic [VRF_AW-1:0] op_vrf_base_i,
  output logic              data_req_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [31:0]       data_addr_o,
  output logic [31:0]       data_wdata_o,
  input  logic [31:0]       data_rdata_i,
  input  logic              data_err_i,
  output logic [VRF_AW-1:0] vrf_raddr_o,
  input  logic [31:0]       vrf_rdata_i,
  output logic              vrf_we_o,
  output logic [VRF_AW-1:0] vrf_waddr_o,
  output logic [31:0]       vrf_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  vlsu_state_e        state_q;
  vlsu_op_t           op_in, op;
  logic [NWW-1:0]     icnt;
  logic [VRF_AW-1:0]  rcnt_q;
  logic [1:0]         out_q, out_nxt;
  logic               err_q, accept, req, gnt, rv;
  logic [31:0]        stride_in;
`ifdef VCVE2_VLSU_STRIDE_EN
  assign stride_in = op_stride_i;
`else
  logic unused_stride;
  assign unused_stride = ^op_stride_i;
  assign stride_in = 32'(WORD_BYTES);
`endif
  assign op_in = '{we: op_we_i, base: op_base_i, stride: stride_in, nwords: op_nwords_i, vrf_base: op_vrf_base_i};
  assign accept = op_valid_i & op_ready_o;
  // Responses only count while something is outstanding, so stray rvalids are dropped.
  assign rv = data_rvalid_i & (out_q != 2'd0);
  assign req = (state_q == ISSUE) & (icnt < op.nwords) & (out_q < 2'(MAX_OUTSTANDING)) & ~err_q;
  assign gnt = req & data_gnt_i;
  assign out_nxt = out_q + {1'b0, gnt} - {1'b0, rv};
  vcve2_vlsu_addr_gen u_addr_gen (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (accept),
    .step_i      (gnt),
    .op_i        (op_in),
    .op_o        (op),
    .cnt_o       (icnt),
    .vrf_raddr_o (vrf_raddr_o)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      out_q  <= out_nxt;
      rcnt_q <= rcnt_q + VRF_AW'(rv);
      err_q  <= err_q | (rv & data_err_i);
      case (state_q)
        IDLE: if (op_valid_i) begin
          rcnt_q  <= '0;
          err_q   <= 1'b0;
          state_q <= (op_nwords_i == '0) ? DONE : ISSUE;
        end
        ISSUE: if ((gnt && (icnt + 1'b1) == op.nwords) || (rv && data_err_i)) state_q <= DRAIN;
        DRAIN: if (out_nxt == 2'd0) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign op_ready_o   = state_q == IDLE;
  assign busy_o       = state_q != IDLE;
  assign done_o       = state_q == DONE;
  assign err_o        = done_o & err_q;
  assign data_req_o   = req;
  assign data_we_o    = req & op.we;
  assign data_be_o    = 4'hF;
  assign data_addr_o  = op.base;
  assign data_wdata_o = (req & op.we) ? vrf_rdata_i : '0;
  assign vrf_we_o     = rv & ~op.we;
  assign vrf_waddr_o  = op.vrf_base + rcnt_q;
  assign vrf_wdata_o  = vrf_we_o ? data_rdata_i : '0;
endmodule

// File: tb/tb_vcve2_vlsu_seq.sv
// tb_vcve2_vlsu_seq: table-driven bench with an OBI memory model and scoreboard queues
module tb_vcve2_vlsu_seq;
`ifdef VCVE2_VLSU_STRIDE_EN
  localparam bit STRIDE_EN = 1'b1;
`else
  localparam bit STRIDE_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_ni = 1'b0;
  logic op_valid_i = 1'b0, op_ready_o, op_we_i = 1'b0;
  logic [31:0] op_base_i = '0, op_stride_i = '0;
  logic [5:0] op_nwords_i = '0;
  logic [4:0] op_vrf_base_i = '0;
  logic data_req_o, data_gnt_i = 1'b0, data_rvalid_i = 1'b0, data_we_o, data_err_i = 1'b0;
  logic [3:0] data_be_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i = '0, vrf_rdata_i, vrf_wdata_o;
  logic [4:0] vrf_raddr_o, vrf_waddr_o;
  logic vrf_we_o, busy_o, done_o, err_o;
  logic [31:0] vrf_mem [32];
  assign vrf_rdata_i = vrf_mem[vrf_raddr_o];
  always #5 clk = ~clk;
  vcve2_vlsu_seq dut (
    .clk_i(clk), .rst_ni(rst_ni), .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .op_we_i(op_we_i), .op_base_i(op_base_i), .op_stride_i(op_stride_i),
    .op_nwords_i(op_nwords_i), .op_vrf_base_i(op_vrf_base_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_addr_o(data_addr_o),
    .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
    .vrf_raddr_o(vrf_raddr_o), .vrf_rdata_i(vrf_rdata_i), .vrf_we_o(vrf_we_o),
    .vrf_waddr_o(vrf_waddr_o), .vrf_wdata_o(vrf_wdata_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );
  typedef struct {
    logic we; logic [31:0] base; logic [31:0] stride; int nw; int vb;
    int lat; int stall; int err_idx; int gnts; logic xerr; int xlat;
  } vec_t;
  typedef struct {int due; logic [31:0] data; logic err;} rsp_t;
  vec_t vt [8];
  rsp_t pend [$];
  logic [31:0] exp_addr [$], exp_wd [$];
  logic [36:0] exp_vw [$];
  int tests = 0, fails = 0, cyc = 0;
  int lat_cfg = 1, stall_cfg = 0, stall_left = 0, err_idx = -1, gnt_n = 0, rsp_n = 0;
  int done_n = 0, done_cyc = 0, start_cyc = 0;
  logic done_err = 1'b0, cur_we = 1'b0, stray = 1'b0, hold_v = 1'b0;
  logic [4:0] cur_vb = '0;
  logic [64:0] hold = '0;
  function automatic logic [31:0] mem_data(logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction
  task automatic check(string name, logic [71:0] act, logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    rsp_t r;
    int outq;
    logic g;
    @(negedge clk);
    cyc++;
    outq = gnt_n - rsp_n;
    data_rvalid_i = 1'b0;
    data_err_i = 1'b0;
    data_rdata_i = '0;
    if (stray) begin
      data_rvalid_i = 1'b1;
      data_rdata_i = 32'hDEAD_BEEF;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      data_rvalid_i = 1'b1;
      data_rdata_i = r.data;
      data_err_i = r.err;
      rsp_n++;
    end
    g = data_req_o && stall_left == 0;
    if (data_req_o && stall_left > 0) stall_left--;
    data_gnt_i = g;
    if (hold_v && data_req_o) check("req_stable", {data_addr_o, data_we_o, data_wdata_o}, hold);
    hold_v = data_req_o && !g;
    hold = {data_addr_o, data_we_o, data_wdata_o};
    if (g) begin
      if (exp_addr.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_req: got addr %0h expected no request", data_addr_o);
      end else begin
        check("gnt_addr", data_addr_o, exp_addr.pop_front());
        check("gnt_we", data_we_o, cur_we);
        if (cur_we) check("gnt_wdata", data_wdata_o, exp_wd.pop_front());
        check("outstanding_below_max", outq < 2, 1);
      end
      pend.push_back('{cyc + lat_cfg, mem_data(data_addr_o), gnt_n == err_idx});
      if (!cur_we) exp_vw.push_back({5'(cur_vb + 5'(gnt_n)), mem_data(data_addr_o)});
      gnt_n++;
      stall_left = stall_cfg;
    end
    #1;
    if (vrf_we_o) begin
      if (exp_vw.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_vrf_write: got idx %0h data %0h expected none", vrf_waddr_o, vrf_wdata_o);
      end else check("vrf_write", {vrf_waddr_o, vrf_wdata_o}, exp_vw.pop_front());
    end
    if (done_o) begin
      done_n++;
      done_err = err_o;
      done_cyc = cyc;
    end
  endtask
  task automatic check_rst(string tag);
    check({tag, "_ctl"}, {op_ready_o, busy_o, data_req_o, data_we_o, done_o, err_o, vrf_we_o}, 7'b1000000);
    check({tag, "_be"}, data_be_o, 4'hF);
    check({tag, "_addr"}, data_addr_o, 32'h0);
    check({tag, "_wd"}, {data_wdata_o, vrf_wdata_o}, 64'h0);
    check({tag, "_vrfidx"}, {vrf_raddr_o, vrf_waddr_o}, 10'h0);
  endtask
  task automatic start_op(vec_t v);
    logic [31:0] s, a;
    s = STRIDE_EN ? v.stride : 32'd4;
    a = v.base;
    lat_cfg = v.lat; stall_cfg = v.stall; stall_left = v.stall; err_idx = v.err_idx;
    gnt_n = 0; rsp_n = 0; done_n = 0; hold_v = 1'b0;
    cur_we = v.we; cur_vb = 5'(v.vb);
    for (int i = 0; i < v.gnts; i++) begin
      exp_addr.push_back(a);
      if (v.we) exp_wd.push_back(vrf_mem[5'(v.vb + i)]);
      a = a + s;
    end
    op_we_i = v.we; op_base_i = v.base; op_stride_i = v.stride;
    op_nwords_i = 6'(v.nw); op_vrf_base_i = 5'(v.vb);
    op_valid_i = 1'b1;
    start_cyc = cyc;
    step();
    op_valid_i = 1'b0;
  endtask
  task automatic run_op(vec_t v, int id);
    string t;
    t = $sformatf("op%0d", id);
    start_op(v);
    for (int k = 0; k < 200 && done_n == 0; k++) step();
    check({t, "_done_seen"}, done_n, 1);
    check({t, "_err"}, done_err, v.xerr);
    if (v.xlat > 0) check({t, "_latency"}, done_cyc - start_cyc, v.xlat);
    step();
    step();
    check({t, "_done_once"}, done_n, 1);
    check({t, "_grants"}, gnt_n, v.gnts);
    check({t, "_pending_left"}, {exp_addr.size(), exp_vw.size()}, 0);
    check({t, "_idle"}, {op_ready_o, busy_o}, 2'b10);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) vrf_mem[i] = 32'hA000_0000 ^ (32'(i) * 32'h0101_0101);
    vt[0] = '{1'b0, 32'h1000, 32'd4, 4, 8, 1, 0, -1, 4, 1'b0, 6};
    vt[1] = '{1'b1, 32'h2000, 32'hFFFF_FFF8, 3, 20, 1, 2, -1, 3, 1'b0, 0};
    vt[2] = '{1'b0, 32'h3000, 32'd4, 4, 0, 3, 0, -1, 4, 1'b0, 0};
    vt[3] = '{1'b0, 32'h4000, 32'd4, 4, 12, 1, 0, 1, 3, 1'b1, 5};
    vt[4] = '{1'b0, 32'h5000, 32'd4, 1, 31, 1, 0, -1, 1, 1'b0, 3};
    vt[5] = '{1'b0, 32'h6000, 32'd4, 0, 0, 1, 0, -1, 0, 1'b0, 1};
    vt[6] = '{1'b0, 32'hFFFF_FFFC, 32'd4, 2, 31, 1, 0, -1, 2, 1'b0, 4};
    vt[7] = '{1'b1, 32'h7000, 32'd4, 8, 28, 2, 1, -1, 8, 1'b0, 0};
    repeat (2) step();
    check_rst("reset");
    rst_ni = 1'b1;
    step();
    check_rst("idle");
    for (int i = 0; i < 8; i++) run_op(vt[i], i);
    start_op(vt[2]);
    step();
    step();
    rst_ni = 1'b0;
    #1;
    check_rst("mid_reset");
    pend.delete(); exp_addr.delete(); exp_wd.delete(); exp_vw.delete();
    hold_v = 1'b0;
    step();
    rst_ni = 1'b1;
    stray = 1'b1;
    step();
    check("stray_no_vrf_write", vrf_we_o, 1'b0);
    check("stray_ready", {op_ready_o, busy_o}, 2'b10);
    stray = 1'b0;
    step();
    run_op(vt[4], 8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
